// File: rtl/operand_regfile_pkg.sv
// Shared types and sizes for the 8-bit core operand register file.
package operand_regfile_pkg;

    localparam int REG_W    = 8;
    localparam int NUM_REGS = 16;

    typedef logic [3:0]       reg_addr_t;
    typedef logic [REG_W-1:0] word_t;

endpackage

// File: rtl/operand_regfile_if.sv
// Read, write and flag bus between the core datapath and the operand register file.
import operand_regfile_pkg::*;

interface operand_regfile_if;

    reg_addr_t RdAddrA;
    reg_addr_t RdAddrB;
    word_t     RdDataA;
    word_t     RdDataB;
    word_t     RdDataC;

    logic      WrEnAlu;
    reg_addr_t WrAddrAlu;
    word_t     WrDataAlu;

    logic      WrEnLd;
    reg_addr_t WrAddrLd;
    word_t     WrDataLd;

    logic      OvWrEn;
    logic      OvIn;
    logic      OvFlag;

    modport master (
        output RdAddrA, RdAddrB,
        input  RdDataA, RdDataB, RdDataC,
        output WrEnAlu, WrAddrAlu, WrDataAlu,
        output WrEnLd, WrAddrLd, WrDataLd,
        output OvWrEn, OvIn,
        input  OvFlag
    );

    modport slave (
        input  RdAddrA, RdAddrB,
        output RdDataA, RdDataB, RdDataC,
        input  WrEnAlu, WrAddrAlu, WrDataAlu,
        input  WrEnLd, WrAddrLd, WrDataLd,
        input  OvWrEn, OvIn,
        output OvFlag
    );

endinterface

// File: rtl/operand_regfile.sv
// Architectural register file plus overflow flag feeding the ALU sources.
// Define RF_BYPASS_EN for same-cycle write-to-read forwarding.
import operand_regfile_pkg::*;

module operand_regfile #(
    parameter int W         = REG_W,
    parameter int NREGS     = NUM_REGS,
    parameter int SRC_C_IDX = 15
) (
    input logic              Clk,
    input logic              Reset_n,
    operand_regfile_if.slave bus
);

    localparam reg_addr_t C_ADDR = reg_addr_t'(SRC_C_IDX);

    logic [W-1:0] regs [NREGS];
    logic         ov_q;

    logic         ld_ok;
    logic         alu_ok;
    logic [W-1:0] stored_a;
    logic [W-1:0] stored_b;
    logic [W-1:0] stored_c;

    // Out-of-range destinations never match a register and are dropped.
    assign ld_ok  = bus.WrEnLd  && (int'(bus.WrAddrLd)  < NREGS);
    assign alu_ok = bus.WrEnAlu && (int'(bus.WrAddrAlu) < NREGS);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
            ov_q <= 1'b0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (ld_ok && bus.WrAddrLd == reg_addr_t'(i)) begin
                    regs[i] <= bus.WrDataLd;
                end else if (alu_ok && bus.WrAddrAlu == reg_addr_t'(i)) begin
                    regs[i] <= bus.WrDataAlu;
                end
            end
            if (bus.OvWrEn) begin
                ov_q <= bus.OvIn;
            end
        end
    end

    assign stored_a = (int'(bus.RdAddrA) < NREGS) ? regs[bus.RdAddrA] : '0;
    assign stored_b = (int'(bus.RdAddrB) < NREGS) ? regs[bus.RdAddrB] : '0;
    assign stored_c = (SRC_C_IDX < NREGS) ? regs[C_ADDR] : '0;

`ifdef RF_BYPASS_EN
    // Load data has priority over the ALU result, same as on the write edge.
    always_comb begin
        bus.RdDataA = stored_a;
        bus.RdDataB = stored_b;
        bus.RdDataC = stored_c;
        bus.OvFlag  = bus.OvWrEn ? bus.OvIn : ov_q;
        if (ld_ok && bus.WrAddrLd == bus.RdAddrA) begin
            bus.RdDataA = bus.WrDataLd;
        end else if (alu_ok && bus.WrAddrAlu == bus.RdAddrA) begin
            bus.RdDataA = bus.WrDataAlu;
        end
        if (ld_ok && bus.WrAddrLd == bus.RdAddrB) begin
            bus.RdDataB = bus.WrDataLd;
        end else if (alu_ok && bus.WrAddrAlu == bus.RdAddrB) begin
            bus.RdDataB = bus.WrDataAlu;
        end
        if (ld_ok && bus.WrAddrLd == C_ADDR) begin
            bus.RdDataC = bus.WrDataLd;
        end else if (alu_ok && bus.WrAddrAlu == C_ADDR) begin
            bus.RdDataC = bus.WrDataAlu;
        end
    end
`else
    always_comb begin
        bus.RdDataA = stored_a;
        bus.RdDataB = stored_b;
        bus.RdDataC = stored_c;
        bus.OvFlag  = ov_q;
    end
`endif

endmodule
